// File: rtl/cr_osf_dbg_step_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cr_osf_dbg_step_ctl_pkg
//  Description : Shared types for the OSF per-channel debug flow control.
//                Holds the debug-mode encoding written by the OSF debug
//                registers, the decoded per-channel state, and the default
//                step credit width.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package cr_osf_dbg_step_ctl_pkg;

    localparam int STEP_W_DEFAULT = 8;

    // Debug-mode encoding as written by the OSF debug registers.
    typedef enum logic [1:0] {
        OSF_DEBUG_NORMAL     = 2'd0,
        OSF_DEBUG_BLOCK_RDWR = 2'd1,
        OSF_DEBUG_BLOCK_RD   = 2'd2,
        OSF_DEBUG_SS         = 2'd3
    } osf_debug_mode_e;

    // Per-channel operating state, derived from the registered mode and
    // whether any step credit remains.
    typedef enum logic [2:0] {
        NORM     = 3'd0,
        BLK_RDWR = 3'd1,
        BLK_RD   = 3'd2,
        SS_WAIT  = 3'd3,
        SS_RUN   = 3'd4
    } osf_dbg_ch_state_e;

    function automatic osf_dbg_ch_state_e dbg_ch_state(
        input osf_debug_mode_e mode,
        input logic            credit_nz
    );
        osf_dbg_ch_state_e st;
        case (mode)
            OSF_DEBUG_BLOCK_RDWR: st = BLK_RDWR;
            OSF_DEBUG_BLOCK_RD:   st = BLK_RD;
            OSF_DEBUG_SS:         st = credit_nz ? SS_RUN : SS_WAIT;
            default:              st = NORM;
        endcase
        return st;
    endfunction

endpackage : cr_osf_dbg_step_ctl_pkg
`default_nettype wire

// File: rtl/cr_osf_dbg_step_ctl_step_chan.sv
`default_nettype none
// ============================================================================
//  Module      : cr_osf_dbg_step_chan
//  Description : One channel of OSF debug flow control: registered mode,
//                counted single-step credit counter, state decode, FIFO
//                read/write gating and step_done pulse.
//  Ports       : clk/rst          - core clock, async active-high reset
//                mode_i           - raw debug mode for this channel
//                step_req_i       - single-cycle step pulse
//                step_cnt_i       - reads granted per step (0 means 1)
//                fifo_empty_i/fifo_full_i/ob_rd_ok_i/src_empty_i
//                                 - live FIFO and handshake inputs
//                fifo_hw_rd_o/fifo_hw_wr_o/fifo_empty_mod_o
//                                 - gated FIFO controls
//                step_credit_o    - remaining credit (flop)
//                step_done_o      - credit drained by a read (flop)
//  Revision    : 1.0 - initial release
// ============================================================================
module cr_osf_dbg_step_chan
    import cr_osf_dbg_step_ctl_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic              step_req_i,
    input  logic [STEP_W-1:0] step_cnt_i,
    input  logic              fifo_empty_i,
    input  logic              fifo_full_i,
    input  logic              ob_rd_ok_i,
    input  logic              src_empty_i,
    output logic              fifo_hw_rd_o,
    output logic              fifo_hw_wr_o,
    output logic              fifo_empty_mod_o,
    output logic [STEP_W-1:0] step_credit_o,
    output logic              step_done_o
);

    osf_debug_mode_e   mode_q;
    logic [STEP_W-1:0] credit_q, credit_d;
    logic              done_q, done_d;
    osf_dbg_ch_state_e w_state;

    logic              w_is_ss;
    logic              w_norm_wr;
    logic [STEP_W-1:0] w_cnt_eff;
    logic [STEP_W:0]   w_load;
    logic [STEP_W:0]   w_sum;

    assign w_is_ss   = (mode_q == OSF_DEBUG_SS);
    assign w_state   = dbg_ch_state(mode_q, credit_q != '0);
    assign w_norm_wr = !src_empty_i && !fifo_full_i;

    // Gating depends only on registered state and live FIFO/handshake
    // inputs, never on the raw mode or step request.
    always_comb begin
        fifo_hw_rd_o     = 1'b0;
        fifo_hw_wr_o     = w_norm_wr;
        fifo_empty_mod_o = 1'b1;
        case (w_state)
            NORM: begin
                fifo_hw_rd_o     = ob_rd_ok_i;
                fifo_empty_mod_o = fifo_empty_i;
            end
            BLK_RDWR: begin
                fifo_hw_wr_o     = 1'b0;
            end
            SS_RUN: begin
                fifo_hw_rd_o     = ob_rd_ok_i && !fifo_empty_i;
                fifo_empty_mod_o = fifo_empty_i;
            end
            default: begin
                // BLK_RD and SS_WAIT: reads held off, writes as normal.
                fifo_hw_rd_o     = 1'b0;
            end
        endcase
    end

    // Credit arithmetic is one bit wider so a load at or near full scale
    // can be detected and clamped instead of wrapping. A read only happens
    // with credit > 0, so the subtraction never goes negative.
    assign w_cnt_eff = (step_cnt_i == '0) ? STEP_W'(1) : step_cnt_i;
    assign w_load    = step_req_i ? {1'b0, w_cnt_eff} : '0;
    assign w_sum     = {1'b0, credit_q} + w_load - (STEP_W+1)'(fifo_hw_rd_o);

    always_comb begin
        credit_d = '0;
        done_d   = 1'b0;
        if (w_is_ss) begin
            credit_d = w_sum[STEP_W] ? '1 : w_sum[STEP_W-1:0];
            // Drained by the final read; a coincident reload keeps it alive.
            done_d   = (credit_q == STEP_W'(1)) && fifo_hw_rd_o && !step_req_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= OSF_DEBUG_NORMAL;
            credit_q <= '0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= osf_debug_mode_e'(mode_i);
            credit_q <= credit_d;
            done_q   <= done_d;
        end
    end

    assign step_credit_o = credit_q;
    assign step_done_o   = done_q;

endmodule : cr_osf_dbg_step_chan
`default_nettype wire

// File: rtl/cr_osf_dbg_step_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : cr_osf_dbg_step_ctl
//  Description : Multi-channel OSF debug flow control. Each channel runs
//                normal, block-read/write, block-read or counted single-step
//                mode independently; see cr_osf_dbg_step_chan.
//  Ports       : fifo_debug_mode - 2 bits per channel, ch i at [2i+1:2i]
//                step_req        - per-channel step pulse
//                step_cnt        - shared reads-per-step count
//                fifo_empty/fifo_full/ob_rd_ok/src_empty - per-channel inputs
//                fifo_hw_rd/fifo_hw_wr/fifo_empty_mod    - per-channel outputs
//                step_credit     - STEP_W bits per channel, ch i at
//                                  [i*STEP_W +: STEP_W]
//                step_done       - per-channel drain pulse
//  Revision    : 1.0 - replaces single-channel debug control
// ============================================================================
module cr_osf_dbg_step_ctl
    import cr_osf_dbg_step_ctl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int STEP_W = STEP_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*NUM_CH-1:0]      fifo_debug_mode,
    input  logic [NUM_CH-1:0]        step_req,
    input  logic [STEP_W-1:0]        step_cnt,
    input  logic [NUM_CH-1:0]        fifo_empty,
    input  logic [NUM_CH-1:0]        fifo_full,
    input  logic [NUM_CH-1:0]        ob_rd_ok,
    input  logic [NUM_CH-1:0]        src_empty,
    output logic [NUM_CH-1:0]        fifo_hw_rd,
    output logic [NUM_CH-1:0]        fifo_hw_wr,
    output logic [NUM_CH-1:0]        fifo_empty_mod,
    output logic [NUM_CH*STEP_W-1:0] step_credit,
    output logic [NUM_CH-1:0]        step_done
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        cr_osf_dbg_step_chan #(
            .STEP_W (STEP_W)
        ) u_chan (
            .clk              (clk),
            .rst              (rst),
            .mode_i           (fifo_debug_mode[2*gi +: 2]),
            .step_req_i       (step_req[gi]),
            .step_cnt_i       (step_cnt),
            .fifo_empty_i     (fifo_empty[gi]),
            .fifo_full_i      (fifo_full[gi]),
            .ob_rd_ok_i       (ob_rd_ok[gi]),
            .src_empty_i      (src_empty[gi]),
            .fifo_hw_rd_o     (fifo_hw_rd[gi]),
            .fifo_hw_wr_o     (fifo_hw_wr[gi]),
            .fifo_empty_mod_o (fifo_empty_mod[gi]),
            .step_credit_o    (step_credit[gi*STEP_W +: STEP_W]),
            .step_done_o      (step_done[gi])
        );
    end : g_ch

endmodule : cr_osf_dbg_step_ctl
`default_nettype wire

// File: tb/tb_cr_osf_dbg_step_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cr_osf_dbg_step_ctl
//  Description : Directed bench for cr_osf_dbg_step_ctl, NUM_CH=4, STEP_W=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_osf_dbg_step_ctl;

    localparam int NUM_CH = 4;
    localparam int STEP_W = 4;

    logic                     clk;
    logic                     rst;
    logic [2*NUM_CH-1:0]      fifo_debug_mode;
    logic [NUM_CH-1:0]        step_req;
    logic [STEP_W-1:0]        step_cnt;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH-1:0]        fifo_full;
    logic [NUM_CH-1:0]        ob_rd_ok;
    logic [NUM_CH-1:0]        src_empty;
    logic [NUM_CH-1:0]        fifo_hw_rd;
    logic [NUM_CH-1:0]        fifo_hw_wr;
    logic [NUM_CH-1:0]        fifo_empty_mod;
    logic [NUM_CH*STEP_W-1:0] step_credit;
    logic [NUM_CH-1:0]        step_done;

    int n_vec;
    int n_err;

    cr_osf_dbg_step_ctl #(
        .NUM_CH (NUM_CH),
        .STEP_W (STEP_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_debug_mode (fifo_debug_mode),
        .step_req        (step_req),
        .step_cnt        (step_cnt),
        .fifo_empty      (fifo_empty),
        .fifo_full       (fifo_full),
        .ob_rd_ok        (ob_rd_ok),
        .src_empty       (src_empty),
        .fifo_hw_rd      (fifo_hw_rd),
        .fifo_hw_wr      (fifo_hw_wr),
        .fifo_empty_mod  (fifo_empty_mod),
        .step_credit     (step_credit),
        .step_done       (step_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cred(input int ch);
        return int'(step_credit[ch*STEP_W +: STEP_W]);
    endfunction

    task automatic set_mode(input int ch, input logic [1:0] m);
        fifo_debug_mode[2*ch +: 2] = m;
    endtask

    int rd_cnt;

    initial begin
        int exp_cr [5] = '{3, 2, 1, 0, 0};
        int exp_rd [5] = '{1, 1, 1, 0, 0};
        int exp_dn [5] = '{0, 0, 0, 1, 0};
        int i1_cr  [4] = '{2, 1, 0, 0};
        int i1_rd  [4] = '{1, 1, 0, 0};
        int i1_dn  [4] = '{0, 0, 1, 0};

        n_vec = 0;
        n_err = 0;
        rst             = 1'b1;
        fifo_debug_mode = '0;
        step_req        = '0;
        step_cnt        = '0;
        fifo_empty      = '0;
        fifo_full       = '0;
        ob_rd_ok        = '1;
        src_empty       = '0;

        // ---------------- reset state ----------------
        #3;
        chk_eq("rst_credit", int'(step_credit), 0);
        chk_eq("rst_done", int'(step_done), 0);
        chk_eq("rst_rd", int'(fifo_hw_rd), 15);
        chk_eq("rst_empty_mod", int'(fifo_empty_mod), 0);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- per-mode gating, ch0 ----------------
        tick();
        set_mode(0, 2'd1);
        #1;
        chk_eq("blkrdwr_pre_rd", int'(fifo_hw_rd[0]), 1);
        tick();
        chk_eq("blkrdwr_rd", int'(fifo_hw_rd[0]), 0);
        chk_eq("blkrdwr_wr", int'(fifo_hw_wr[0]), 0);
        chk_eq("blkrdwr_em", int'(fifo_empty_mod[0]), 1);
        set_mode(0, 2'd2);
        #1;
        chk_eq("blkrd_pre_wr", int'(fifo_hw_wr[0]), 0);
        tick();
        chk_eq("blkrd_rd", int'(fifo_hw_rd[0]), 0);
        chk_eq("blkrd_wr", int'(fifo_hw_wr[0]), 1);
        chk_eq("blkrd_em", int'(fifo_empty_mod[0]), 1);
        set_mode(0, 2'd0);
        tick();
        chk_eq("norm_rd", int'(fifo_hw_rd[0]), 1);
        chk_eq("norm_wr", int'(fifo_hw_wr[0]), 1);
        chk_eq("norm_em", int'(fifo_empty_mod[0]), 0);

        // ---------------- counted step, step_cnt=3 ----------------
        set_mode(0, 2'd3);
        tick();
        chk_eq("sswait_rd", int'(fifo_hw_rd[0]), 0);
        chk_eq("sswait_em", int'(fifo_empty_mod[0]), 1);
        chk_eq("sswait_wr", int'(fifo_hw_wr[0]), 1);
        step_cnt    = 4'd3;
        step_req[0] = 1'b1;
        #1;
        chk_eq("ss_req_no_comb_rd", int'(fifo_hw_rd[0]), 0);
        tick();
        step_req[0] = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk_eq($sformatf("step3_credit[%0d]", k), cred(0), exp_cr[k]);
            chk_eq($sformatf("step3_rd[%0d]", k), int'(fifo_hw_rd[0]), exp_rd[k]);
            chk_eq($sformatf("step3_done[%0d]", k), int'(step_done[0]), exp_dn[k]);
            rd_cnt += int'(fifo_hw_rd[0]);
            tick();
        end
        chk_eq("step3_rd_total", rd_cnt, 3);
        chk_eq("step3_em_after", int'(fifo_empty_mod[0]), 1);

        // ---------------- step_cnt=0 grants one read ----------------
        step_cnt    = 4'd0;
        step_req[0] = 1'b1;
        tick();
        step_req[0] = 1'b0;
        #1;
        chk_eq("cnt0_credit", cred(0), 1);
        chk_eq("cnt0_rd", int'(fifo_hw_rd[0]), 1);
        tick();
        chk_eq("cnt0_credit_after", cred(0), 0);
        chk_eq("cnt0_rd_after", int'(fifo_hw_rd[0]), 0);
        chk_eq("cnt0_done", int'(step_done[0]), 1);

        // ---------------- saturation at 15 ----------------
        ob_rd_ok[0] = 1'b0;
        step_cnt    = 4'd14;
        step_req[0] = 1'b1;
        tick();
        chk_eq("sat_credit14", cred(0), 14);
        chk_eq("ssrun_em", int'(fifo_empty_mod[0]), 0);
        step_cnt = 4'd5;
        tick();
        chk_eq("sat_credit15", cred(0), 15);
        tick();
        step_req[0] = 1'b0;
        chk_eq("sat_absorb", cred(0), 15);

        // ---------------- drain to 1, then step with coincident read ----------------
        ob_rd_ok[0] = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk_eq("drain_credit1", cred(0), 1);
        step_cnt    = 4'd2;
        step_req[0] = 1'b1;
        #1;
        chk_eq("coinc_rd", int'(fifo_hw_rd[0]), 1);
        tick();
        step_req[0] = 1'b0;
        ob_rd_ok[0] = 1'b0;
        chk_eq("coinc_credit", cred(0), 2);
        chk_eq("coinc_no_done", int'(step_done[0]), 0);

        // ---------------- mode exit discards credit ----------------
        step_req[0] = 1'b1;
        tick();
        step_req[0] = 1'b0;
        chk_eq("exit_credit4", cred(0), 4);
        set_mode(0, 2'd0);
        tick();
        ob_rd_ok[0] = 1'b1;
        #1;
        chk_eq("exit_norm_rd", int'(fifo_hw_rd[0]), 1);
        set_mode(0, 2'd3);
        tick();
        chk_eq("reenter_credit", cred(0), 0);
        chk_eq("reenter_rd", int'(fifo_hw_rd[0]), 0);
        chk_eq("reenter_em", int'(fifo_empty_mod[0]), 1);
        tick();
        chk_eq("reenter_rd2", int'(fifo_hw_rd[0]), 0);

        // ---------------- channel independence ----------------
        set_mode(1, 2'd3);
        set_mode(2, 2'd2);
        set_mode(3, 2'd0);
        fifo_empty[3] = 1'b1;
        tick();
        step_cnt = 4'd2;
        step_req = 4'b0010;
        tick();
        for (int k = 0; k < 4; k++) begin
            step_req = (k == 1) ? 4'b1100 : 4'b0000;
            #1;
            chk_eq($sformatf("ind_ch1_credit[%0d]", k), cred(1), i1_cr[k]);
            chk_eq($sformatf("ind_ch1_rd[%0d]", k), int'(fifo_hw_rd[1]), i1_rd[k]);
            chk_eq($sformatf("ind_ch1_done[%0d]", k), int'(step_done[1]), i1_dn[k]);
            chk_eq($sformatf("ind_ch0_credit[%0d]", k), cred(0), 0);
            chk_eq($sformatf("ind_ch2_credit[%0d]", k), cred(2), 0);
            chk_eq($sformatf("ind_ch3_credit[%0d]", k), cred(3), 0);
            chk_eq($sformatf("ind_ch2_gate[%0d]", k),
                   int'({fifo_hw_rd[2], fifo_hw_wr[2], fifo_empty_mod[2]}), 3);
            chk_eq($sformatf("ind_ch3_gate[%0d]", k),
                   int'({fifo_hw_rd[3], fifo_hw_wr[3], fifo_empty_mod[3]}), 7);
            chk_eq($sformatf("ind_ch0_rd[%0d]", k), int'(fifo_hw_rd[0]), 0);
            tick();
        end
        step_req      = '0;
        fifo_empty[3] = 1'b0;

        // ---------------- reset mid-SS_RUN ----------------
        ob_rd_ok[0] = 1'b0;
        step_cnt    = 4'd5;
        step_req[0] = 1'b1;
        tick();
        step_req[0] = 1'b0;
        chk_eq("prerst_credit5", cred(0), 5);
        ob_rd_ok = '1;
        #2;
        rst = 1'b1;
        #1;
        chk_eq("midrst_credit", int'(step_credit), 0);
        chk_eq("midrst_done", int'(step_done), 0);
        chk_eq("midrst_rd", int'(fifo_hw_rd), 15);
        chk_eq("midrst_wr", int'(fifo_hw_wr), 15);
        chk_eq("midrst_em", int'(fifo_empty_mod), 0);
        tick();
        chk_eq("midrst_credit_hold", int'(step_credit), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute safety bound on simulated time.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_cr_osf_dbg_step_ctl
`default_nettype wire

// File: doc/cr_osf_dbg_step_ctl.md
# cr_osf_dbg_step_ctl

Multi-channel, parametrised debug flow-control block for the OSF output FIFOs. Each of NUM_CH channels independently runs normal, block-read/write, block-read or counted single-step debug mode. Counted single-step adds a per-channel step credit counter, so one `step_req` pulse releases up to `step_cnt` FIFO reads instead of gating reads combinationally with a level. The block sits between the OSF debug registers and the per-channel FIFO read/write enables, and replaces the single-channel debug control.

## Interface
Parameters:
- NUM_CH, 4, number of FIFO channels (1..16)
- STEP_W, 8, width of step count and per-channel credit counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- fifo_debug_mode  in  2*NUM_CH  per-channel osf_debug_mode_e; ch i at [2i+1:2i]
- step_req  in  NUM_CH  per-channel single-cycle step pulse
- step_cnt  in  STEP_W  reads granted per step_req; 0 is treated as 1
- fifo_empty  in  NUM_CH  raw FIFO empty
- fifo_full  in  NUM_CH  raw FIFO full
- ob_rd_ok  in  NUM_CH  downstream read-accept
- src_empty  in  NUM_CH  upstream source empty
- fifo_hw_rd  out  NUM_CH  FIFO read enable
- fifo_hw_wr  out  NUM_CH  FIFO write enable
- fifo_empty_mod  out  NUM_CH  empty flag presented downstream
- step_credit  out  NUM_CH*STEP_W  remaining credit per channel; reset 0
- step_done  out  NUM_CH  1-cycle pulse when credit reaches 0 by a read; reset 0

## Operation
- mode_q[i] registers fifo_debug_mode[i]. All gating uses mode_q, so a mode change takes effect one cycle after it is presented. mode_q resets to OSF_DEBUG_NORMAL.
- Per-channel state, derived from mode_q and credit: NORM, BLK_RDWR, BLK_RD, SS_WAIT (SS with credit==0), SS_RUN (SS with credit>0).
- NORM: rd=ob_rd_ok; empty_mod=fifo_empty; wr=!src_empty&&!fifo_full.
- BLK_RDWR: rd=0; empty_mod=1; wr=0.
- BLK_RD: rd=0; empty_mod=1; wr as NORM.
- SS_WAIT: rd=0; empty_mod=1; wr as NORM.
- SS_RUN: rd=ob_rd_ok&&!fifo_empty; empty_mod=fifo_empty; wr as NORM.
- Credit update applies only when mode_q==SS. Load L = step_req ? max(step_cnt,1) : 0. Decrement D = fifo_hw_rd. credit_next = min(credit+L-D, 2^STEP_W-1), computed at STEP_W+1 bits.
- Simultaneous step_req and read: both apply in the same cycle.
- Saturation: additional step_req at max credit is absorbed; no wrap.
- step_req in any non-SS mode is ignored.
- Any cycle where mode_q is not SS clears credit to 0. Leaving SS discards remaining credit, and re-entering SS always starts in SS_WAIT.
- step_done[i]=1 for one cycle when credit goes 1->0 by a read with no coincident load. Registered, so it asserts the cycle after that read.
- Channels are fully independent; there are no shared counters.
- Reset mid-step: credit, mode_q and step_done clear asynchronously. Outputs then follow NORM with live inputs.

## Timing
- rd/wr/empty_mod are combinational from registered state (mode_q, credit) and live FIFO/handshake inputs. There are no combinational paths from fifo_debug_mode or step_req.
- Mode latency: 1 cycle.
- step_req latency:
  - step_req high at cycle N gives credit valid at N+1.
  - The first possible fifo_hw_rd is at N+1.
- Credit decrements in the cycle after each asserted fifo_hw_rd.
- Credit outputs are taken directly from flops. step_done is a flop.

## Structure
- cr_osfPKG holds:
  - osf_debug_mode_e (existing)
  - osf_dbg_ch_state_e {NORM, BLK_RDWR, BLK_RD, SS_WAIT, SS_RUN}
  - a localparam for the default STEP_W
- Sub-module cr_osf_dbg_step_chan holds one channel's mode_q, credit counter, state decode, gating and step_done. It is parametrised by STEP_W.
- The top instantiates NUM_CH copies in a generate loop and slices the vectors.

## Test plan
- Reset: assert rst mid-SS_RUN with credit 5 -> credit 0, step_done 0, all channels NORM. A fifo_empty=0 channel then shows empty_mod=0.
- Per-mode gating, ch0 (fifo_empty=0, full=0, src_empty=0, ob_rd_ok=1):
  - NORM: rd=1, wr=1, empty_mod=0
  - BLK_RDWR: rd=0, wr=0, empty_mod=1
  - BLK_RD: rd=0, wr=1, empty_mod=1
  - Each takes effect one cycle after the mode write.
- Counted step: SS, step_cnt=3, one step_req, ob_rd_ok held 1 -> exactly 3 rd pulses. Credit goes 3,2,1,0, then step_done for one cycle and empty_mod=1.
- Boundaries, STEP_W=4:
  - step_cnt=0 -> 1 read
  - credit 14 plus step_cnt=5 -> credit 15
  - step_req with a coincident read at credit 1 -> credit = 1+L-1, no step_done
- Mode exit: SS with credit 4, switch to NORM and back to SS -> credit 0, SS_WAIT, no reads until the next step_req.
- Independence, NUM_CH=4: ch1 SS_WAIT, ch2 BLK_RD, ch3 NORM, with step_req on ch1 only -> only ch1 credit changes, and other channel outputs match their modes every cycle.
